// File: rtl/bloom_pkg.sv
// Shared definitions for the flow-key Bloom filter: FSM states, hash seeds, defaults.
// The CLEAR state exists only when BLOOM_CLEAR_EN is defined.
package bloom_pkg;

   localparam int KEY_W_DEF    = 104;
   localparam int NUM_HASH_DEF = 3;
   localparam int ADDR_W_DEF   = 12;

   localparam logic [31:0] GOLDEN = 32'h9E3779B1;

   // One seed per hash function; the fold is shared, the seed decorrelates the indices
   localparam logic [31:0] SEED [0:7] = '{
      32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
      32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89
   };

`ifdef BLOOM_CLEAR_EN
   typedef enum logic [1:0] {ST_IDLE, ST_PROBE, ST_RESULT, ST_CLEAR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_PROBE, ST_RESULT} state_t;
`endif

endpackage

// File: rtl/bloom_hash.sv
// Combinational bit-index hash: XOR-fold key to 32 bits, mix with SEED[i], multiply by
// the golden constant and keep the top ADDR_W bits of the product.
module bloom_hash
   import bloom_pkg::*;
#(
   parameter int KEY_W  = KEY_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [KEY_W-1:0]  key,
   input  logic [2:0]        i,
   output logic [ADDR_W-1:0] idx
);

   localparam int CHUNKS = (KEY_W + 31) / 32;

   logic [CHUNKS*32-1:0] key_pad;
   logic [31:0]          fold;
   logic [31:0]          prod;

   always_comb begin
      key_pad = '0;
      key_pad[KEY_W-1:0] = key;
      fold = '0;
      for (int c = 0; c < CHUNKS; c++) begin
         fold = fold ^ key_pad[c*32 +: 32];
      end
   end

   assign prod = (fold ^ SEED[i]) * GOLDEN;
   assign idx  = prod[31 -: ADDR_W];

endmodule

// File: rtl/bloom_filter_px.sv
// Bloom filter over 2^ADDR_W bits: one hash probe per cycle, NUM_HASH probes per request.
// Optional BLOOM_CLEAR_EN adds clr_req and a word-at-a-time CLEAR state.
module bloom_filter_px
   import bloom_pkg::*;
#(
   parameter int KEY_W    = KEY_W_DEF,
   parameter int NUM_HASH = NUM_HASH_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [KEY_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit
`ifdef BLOOM_CLEAR_EN
   ,
   input  logic             clr_req
`endif
);

   localparam int M         = 2**ADDR_W;
   localparam int CLR_WORDS = (M / 32 > 1) ? M / 32 : 1;

   state_t              state, state_nxt;
   logic                accept;
   logic                cnt_last;
   logic [ADDR_W-1:0]   cnt;
   logic [M-1:0]        bits;
   logic [KEY_W-1:0]    key_p0;
   logic                op_p0;
   logic                hit_acc;
   logic [ADDR_W-1:0]   idx;
   logic                bit_rd;

   bloom_hash #(
      .KEY_W  (KEY_W),
      .ADDR_W (ADDR_W)
   ) u_hash (
      .key (key_p0),
      .i   (cnt[2:0]),
      .idx (idx)
   );

   assign bit_rd    = bits[idx];
   assign out_valid = (state == ST_RESULT);
   assign out_hit   = out_valid & hit_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      in_ready  = 1'b0;
      cnt_last  = 1'b0;
      case (state)
         ST_IDLE: begin
`ifdef BLOOM_CLEAR_EN
            // A pending clear takes priority; the request stays unaccepted
            in_ready = ~clr_req;
            if (clr_req) begin
               state_nxt = ST_CLEAR;
            end else if (in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_PROBE;
            end
`else
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_PROBE;
            end
`endif
         end
         ST_PROBE: begin
            cnt_last = (cnt == ADDR_W'(NUM_HASH - 1));
            if (cnt_last) state_nxt = ST_RESULT;
         end
         ST_RESULT: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
`ifdef BLOOM_CLEAR_EN
         ST_CLEAR: begin
            cnt_last = (cnt == ADDR_W'(CLR_WORDS - 1));
            if (cnt_last) state_nxt = ST_IDLE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage p0: request capture; key carries no reset since it is only read in PROBE
   always_ff @(posedge clk) begin
      if (accept) key_p0 <= in_key;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bits    <= '0;
         cnt     <= '0;
         op_p0   <= 1'b0;
         hit_acc <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_p0   <= in_op;
                  hit_acc <= 1'b1;
                  cnt     <= '0;
               end
            end
            // Read-before-set on the same bit, so the result reflects the array before this request
            ST_PROBE: begin
               hit_acc <= hit_acc & bit_rd;
               if (op_p0) bits[idx] <= 1'b1;
               cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
`ifdef BLOOM_CLEAR_EN
            ST_CLEAR: begin
               bits[{cnt[ADDR_W-6:0], 5'b00000} +: 32] <= '0;
               cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bloom_filter_px.sv
// Directed bench for bloom_filter_px: latency, insert/query hits, back-pressure, reset abort,
// optional clear (BLOOM_CLEAR_EN), and index model check for NUM_HASH=1 and NUM_HASH=8.
module tb_bloom_filter_px;

   localparam int KW = 104;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_op = 1'b0;
   logic [KW-1:0] in_key = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, out_hit;
   logic          clr_req = 1'b0;

   logic          rv = 1'b0;
   logic          rop = 1'b0;
   logic [KW-1:0] rkey = '0;
   logic          r1_ready, r1_valid, r1_hit;
   logic          r8_ready, r8_valid, r8_hit;

   int n_asrt = 0;
   int n_fail = 0;

   localparam logic [31:0] SEEDS_REF [8] = '{
      32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
      32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89
   };

   bit [4095:0] m1 = '0;
   bit [4095:0] m8 = '0;

   always #5 clk = ~clk;

   bloom_filter_px dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit)
`ifdef BLOOM_CLEAR_EN
      , .clr_req(clr_req)
`endif
   );

   bloom_filter_px #(.NUM_HASH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(rv), .in_ready(r1_ready), .in_op(rop),
      .in_key(rkey), .out_valid(r1_valid), .out_ready(1'b1), .out_hit(r1_hit)
`ifdef BLOOM_CLEAR_EN
      , .clr_req(1'b0)
`endif
   );

   bloom_filter_px #(.NUM_HASH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(rv), .in_ready(r8_ready), .in_op(rop),
      .in_key(rkey), .out_valid(r8_valid), .out_ready(1'b1), .out_hit(r8_hit)
`ifdef BLOOM_CLEAR_EN
      , .clr_req(1'b0)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial fold, written independently of the RTL's chunk loop
   function automatic int ref_idx(input logic [KW-1:0] k, input int i);
      logic [31:0] x = '0;
      logic [31:0] m;
      for (int b = 0; b < KW; b++) x[b % 32] = x[b % 32] ^ k[b];
      m = (x ^ SEEDS_REF[i]) * 32'h9E3779B1;
      return int'(m >> 20);
   endfunction

   task automatic model_req(input int nh, input logic op, input logic [KW-1:0] k,
                            inout bit [4095:0] arr, output logic hit);
      int ix;
      hit = 1'b1;
      for (int i = 0; i < nh; i++) begin
         ix = ref_idx(k, i);
         hit = hit & arr[ix];
         if (op) arr[ix] = 1'b1;
      end
   endtask

   task automatic req(input logic op, input logic [KW-1:0] k, output logic hit, output int lat);
      int n = 0;
      in_op = op; in_key = k; in_valid = 1'b1;
      while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      hit = out_hit;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic          hit, mh;
      int            lat, seen, low;
      logic [KW-1:0] k0, kk, k2, k3, k4;

      k0 = {32'h0A000001, 32'h0A000002, 8'h06, 16'h1F90, 16'h0050};
      kk = {32'hC0A80001, 32'hC0A80102, 8'h11, 16'h0035, 16'hD431};
      k2 = {32'h08080808, 32'h01010101, 8'h06, 16'h01BB, 16'h9C40};
      k3 = {32'h7F000001, 32'h7F000002, 8'h01, 16'h0000, 16'h0000};
      k4 = {32'hAC100005, 32'hAC100006, 8'h06, 16'h0016, 16'hE000};

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_hit", out_hit, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // First query after reset: latency 3, miss
      req(1'b0, k0, hit, lat);
      check("q0_latency", lat, 3);
      check("q0_hit", hit, 0);

      // Insert twice then query
      req(1'b1, kk, hit, lat);
      check("ins1_hit", hit, 0);
      check("ins1_latency", lat, 3);
      req(1'b1, kk, hit, lat);
      check("ins2_hit", hit, 1);
      req(1'b0, kk, hit, lat);
      check("qK_hit", hit, 1);

      // Back-pressure: hold out_ready low for 5 cycles with a stray insert pending
      req(1'b1, k2, hit, lat);
      in_op = 1'b0; in_key = k2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_op = 1'b1; in_key = k3;
      seen = 0;
      while (!out_valid && seen < 50) begin @(posedge clk); #1; seen++; end
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", out_valid, 1);
         check("bp_hit", out_hit, 1);
         check("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      check("bp_no_second", seen, 0);
      req(1'b0, k3, hit, lat);
      check("bp_stray_not_inserted", hit, 0);

      // Reset during the second probe cycle of an insert
      in_op = 1'b1; in_key = k4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      check("abort_no_result", seen, 0);
      req(1'b0, k4, hit, lat);
      check("abort_q_hit", hit, 0);
      check("abort_q_latency", lat, 3);
      req(1'b0, kk, hit, lat);
      check("abort_array_cleared", hit, 0);

`ifdef BLOOM_CLEAR_EN
      for (int j = 0; j < 10; j++) req(1'b1, k0 + KW'(j * 7919), hit, lat);
      req(1'b0, k0, hit, lat);
      check("clr_pre_hit", hit, 1);
      clr_req = 1'b1; in_valid = 1'b1; in_op = 1'b1; in_key = k3;
      @(posedge clk); #1;
      clr_req = 1'b0; in_valid = 1'b0;
      low = 0; seen = 0;
      while (!in_ready && low < 400) begin
         if (out_valid) seen++;
         low++;
         @(posedge clk); #1;
      end
      check("clr_low_cycles", low, 128);
      check("clr_req_not_accepted", seen, 0);
      for (int j = 0; j < 10; j++) begin
         req(1'b0, k0 + KW'(j * 7919), hit, lat);
         check("clr_post_hit", hit, 0);
      end
`endif

      // Index model check, NUM_HASH=1 and NUM_HASH=8 side by side
      for (int n = 0; n < 1000; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         rop  = ($urandom_range(0, 3) != 0);
         rv   = 1'b1;
         @(posedge clk); #1;
         rv = 1'b0;
         for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
               model_req(1, rop, rkey, m1, mh);
               check("h1_valid_hit", {r1_valid, r1_hit}, {1'b1, mh});
            end
            if (c == 7) check("h8_early", r8_valid, 0);
            if (c == 8) begin
               model_req(8, rop, rkey, m8, mh);
               check("h8_valid_hit", {r8_valid, r8_hit}, {1'b1, mh});
            end
         end
      end
      check("h1_array", (dut1.bits === m1), 1);
      check("h8_array", (dut8.bits === m8), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
